// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB transmit serializer and bit-stuff counter.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_STUFF,
    ST_EOP
  } tx_state_t;

  localparam logic [7:0]  USB_SYNC_BYTE = 8'h80;
  localparam int unsigned USB_STUFF_LEN = 6;

endpackage

// File: rtl/usb_bitstuff_counter.sv
// Counts consecutive 1s on a serial bit stream and flags when the bit
// currently presented completes a run that must be followed by a stuffed 0.
module usb_bitstuff_counter
  import usb_tx_pkg::*;
#(
  parameter int unsigned STUFF_LEN = USB_STUFF_LEN
) (
  input  logic gclk,
  input  logic reset_l,
  input  logic clr,
  input  logic bit_valid,
  input  logic bit_in,
  output logic stuff_next
);

  localparam int unsigned CNT_W = $clog2(STUFF_LEN + 1);

  logic [CNT_W-1:0] ones_cnt;

  // ones_cnt counts the 1s before the current bit, so a 1 now at STUFF_LEN-1 completes the run
  assign stuff_next = bit_valid && bit_in && (ones_cnt == CNT_W'(STUFF_LEN - 1));

  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      ones_cnt <= '0;
    end else if (clr) begin
      ones_cnt <= '0;
    end else if (bit_valid) begin
      if (bit_in) ones_cnt <= ones_cnt + CNT_W'(1);
      else        ones_cnt <= '0;
    end
  end

endmodule

// File: rtl/usb_tx_bitstuff_serializer.sv
// USB transmit serializer: SYNC prefix, LSB-first byte shifting with
// bit stuffing, and end-of-packet signalling toward the NRZI/EOP stages.
module usb_tx_bitstuff_serializer
  import usb_tx_pkg::*;
#(
  parameter logic [7:0]  SYNC_PATTERN = USB_SYNC_BYTE,
  parameter int unsigned STUFF_LEN    = USB_STUFF_LEN
) (
  input  logic       gclk,
  input  logic       reset_l,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       start_txd,
  output logic       tx_data_in,
  output logic       tx_eop
);

  tx_state_t  state;
  logic [2:0] bit_cnt;
  logic [6:0] shift_reg;
  logic       stuff_last;
  logic       stuff_next;

  usb_bitstuff_counter #(
    .STUFF_LEN (STUFF_LEN)
  ) u_stuff (
    .gclk       (gclk),
    .reset_l    (reset_l),
    .clr        (state == ST_EOP),
    .bit_valid  (start_txd),
    .bit_in     (tx_data_in),
    .stuff_next (stuff_next)
  );

  // Ready marks the final cycle of a unit; a pending stuff pushes it onto the STUFF cycle.
  always_comb begin
    tx_ready = 1'b0;
    unique case (state)
      ST_SYNC, ST_DATA: tx_ready = (bit_cnt == 3'd7) && !stuff_next;
      ST_STUFF:         tx_ready = stuff_last;
      default:          tx_ready = 1'b0;
    endcase
  end

  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      stuff_last <= 1'b0;
      start_txd  <= 1'b0;
      tx_data_in <= 1'b1;
      tx_eop     <= 1'b0;
    end else if (tx_ready) begin
      if (tx_valid) begin
        state      <= ST_DATA;
        bit_cnt    <= '0;
        tx_data_in <= tx_data[0];
        shift_reg  <= tx_data[7:1];
      end else begin
        state      <= ST_EOP;
        start_txd  <= 1'b0;
        tx_data_in <= 1'b1;
        tx_eop     <= 1'b1;
      end
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (tx_valid) begin
            state      <= ST_SYNC;
            bit_cnt    <= '0;
            start_txd  <= 1'b1;
            tx_data_in <= SYNC_PATTERN[0];
          end
        end
        ST_SYNC, ST_DATA: begin
          if (stuff_next) begin
            state      <= ST_STUFF;
            tx_data_in <= 1'b0;
            stuff_last <= (bit_cnt == 3'd7);
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            if (state == ST_SYNC) begin
              tx_data_in <= SYNC_PATTERN[bit_cnt + 3'd1];
            end else begin
              tx_data_in <= shift_reg[0];
              shift_reg  <= {1'b0, shift_reg[6:1]};
            end
          end
        end
        ST_STUFF: begin
          state      <= ST_DATA;
          bit_cnt    <= bit_cnt + 3'd1;
          tx_data_in <= shift_reg[0];
          shift_reg  <= {1'b0, shift_reg[6:1]};
        end
        ST_EOP: begin
          state  <= ST_IDLE;
          tx_eop <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_bitstuff_serializer.sv
// Directed self-checking bench for usb_tx_bitstuff_serializer: expected
// line bit strings and ready patterns are hand-computed per packet.
module tb_usb_tx_bitstuff_serializer;

  logic       gclk = 1'b0;
  logic       reset_l;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       start_txd;
  logic       tx_data_in;
  logic       tx_eop;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [7:0]  pkt [4];
  string       got_bits;
  string       got_ready;
  int unsigned n_ready, n_xfer, n_eop, lead_idle;
  int          ones_eop, ones_first;
  bit          eop_adj;

  always #5 gclk = ~gclk;

  usb_tx_bitstuff_serializer #(
    .SYNC_PATTERN (8'h80),
    .STUFF_LEN    (6)
  ) dut (
    .gclk       (gclk),
    .reset_l    (reset_l),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .start_txd  (start_txd),
    .tx_data_in (tx_data_in),
    .tx_eop     (tx_eop)
  );

  // Sends n bytes from pkt[], recording line bits and ready per active cycle.
  // Must be entered at a negedge; returns at the negedge sample of the EOP cycle.
  task automatic run_packet(input int unsigned n);
    int unsigned idx = 0;
    bit take;
    bit seen_active = 1'b0;
    bit prev_active = 1'b0;
    got_bits = ""; got_ready = "";
    n_ready = 0; n_xfer = 0; n_eop = 0; lead_idle = 0;
    ones_eop = -1; ones_first = -1; eop_adj = 1'b0;
    tx_valid = 1'b1;
    tx_data  = pkt[0];
    if (n == 0) begin
      @(posedge gclk); #1;
      tx_valid = 1'b0;
    end
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge gclk);
      if (cyc == 0) ones_first = int'(dut.u_stuff.ones_cnt);
      if (start_txd) begin
        seen_active = 1'b1;
        got_bits  = {got_bits,  (tx_data_in ? "1" : "0")};
        got_ready = {got_ready, (tx_ready   ? "1" : "0")};
      end else if (!seen_active) begin
        lead_idle++;
      end
      if (tx_ready) n_ready++;
      if (tx_eop) begin
        n_eop++;
        ones_eop = int'(dut.u_stuff.ones_cnt);
        eop_adj  = prev_active;
        break;
      end
      prev_active = start_txd;
      take = tx_ready && tx_valid;
      if (take) n_xfer++;
      @(posedge gclk); #1;
      if (take) begin
        idx++;
        if (idx < n) tx_data = pkt[idx];
        else         tx_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset_l = 1'b0; tx_valid = 1'b0; tx_data = '0;
    #12;
    n_cmp++; if (start_txd !== 1'b0) begin n_bad++; $display("FAIL reset_start_txd: got %b expected 0", start_txd); end
    n_cmp++; if (tx_data_in !== 1'b1) begin n_bad++; $display("FAIL reset_tx_data_in: got %b expected 1", tx_data_in); end
    n_cmp++; if (tx_eop !== 1'b0) begin n_bad++; $display("FAIL reset_tx_eop: got %b expected 0", tx_eop); end
    n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL reset_tx_ready: got %b expected 0", tx_ready); end
    n_cmp++; if (dut.u_stuff.ones_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_ones_cnt: got %0d expected 0", dut.u_stuff.ones_cnt); end
    @(negedge gclk); reset_l = 1'b1;
    @(negedge gclk);
  endtask

  task automatic test_byte_00();
    pkt[0] = 8'h00;
    run_packet(1);
    n_cmp++; if (got_bits != "0000000100000000") begin n_bad++; $display("FAIL b00_bits: got %s expected 0000000100000000", got_bits); end
    n_cmp++; if (got_ready != "0000000100000001") begin n_bad++; $display("FAIL b00_ready: got %s expected 0000000100000001", got_ready); end
    n_cmp++; if (n_ready !== 2) begin n_bad++; $display("FAIL b00_nready: got %0d expected 2", n_ready); end
    n_cmp++; if (n_xfer !== 1) begin n_bad++; $display("FAIL b00_xfer: got %0d expected 1", n_xfer); end
    n_cmp++; if (n_eop !== 1 || eop_adj !== 1'b1) begin n_bad++; $display("FAIL b00_eop: got count %0d adjacent %b expected 1 1", n_eop, eop_adj); end
    n_cmp++; if (start_txd !== 1'b0 || tx_data_in !== 1'b1) begin n_bad++; $display("FAIL b00_eop_line: got start %b data %b expected 0 1", start_txd, tx_data_in); end
    @(negedge gclk);
    n_cmp++; if (tx_eop !== 1'b0 || start_txd !== 1'b0) begin n_bad++; $display("FAIL b00_eop_width: got eop %b start %b expected 0 0", tx_eop, start_txd); end
  endtask

  task automatic test_stuff_ff();
    pkt[0] = 8'hFF;
    run_packet(1);
    n_cmp++; if (got_bits != "00000001111110111") begin n_bad++; $display("FAIL ff_bits: got %s expected 00000001111110111", got_bits); end
    n_cmp++; if (got_ready != "00000001000000001") begin n_bad++; $display("FAIL ff_ready: got %s expected 00000001000000001", got_ready); end
    n_cmp++; if (ones_eop !== 3) begin n_bad++; $display("FAIL ff_ones_end: got %0d expected 3", ones_eop); end
    n_cmp++; if (n_eop !== 1 || eop_adj !== 1'b1) begin n_bad++; $display("FAIL ff_eop: got count %0d adjacent %b expected 1 1", n_eop, eop_adj); end
    @(negedge gclk);
  endtask

  task automatic test_stuff_boundary();
    pkt[0] = 8'hFC; pkt[1] = 8'h00;
    run_packet(2);
    n_cmp++; if (got_bits != "0000000100111111000000000") begin n_bad++; $display("FAIL fc_bits: got %s expected 0000000100111111000000000", got_bits); end
    n_cmp++; if (got_ready != "0000000100000000100000001") begin n_bad++; $display("FAIL fc_ready: got %s expected 0000000100000000100000001", got_ready); end
    n_cmp++; if (n_xfer !== 2 || n_ready !== 3) begin n_bad++; $display("FAIL fc_handshake: got xfer %0d ready %0d expected 2 3", n_xfer, n_ready); end
    n_cmp++; if (n_eop !== 1) begin n_bad++; $display("FAIL fc_eop: got %0d expected 1", n_eop); end
    @(negedge gclk);
  endtask

  task automatic test_back_to_back();
    pkt[0] = 8'h3F; pkt[1] = 8'h01; pkt[2] = 8'hA5;
    run_packet(3);
    n_cmp++; if (got_bits != "000000011111101001000000010100101") begin n_bad++; $display("FAIL b2b_bits: got %s expected 000000011111101001000000010100101", got_bits); end
    n_cmp++; if (got_ready != "000000010000000010000000100000001") begin n_bad++; $display("FAIL b2b_ready: got %s expected 000000010000000010000000100000001", got_ready); end
    n_cmp++; if (n_xfer !== 3) begin n_bad++; $display("FAIL b2b_xfer: got %0d expected 3", n_xfer); end
    n_cmp++; if (n_eop !== 1 || eop_adj !== 1'b1 || ones_eop !== 1) begin n_bad++; $display("FAIL b2b_eop: got count %0d adjacent %b ones %0d expected 1 1 1", n_eop, eop_adj, ones_eop); end
    @(negedge gclk);
  endtask

  task automatic test_empty_packet();
    run_packet(0);
    n_cmp++; if (got_bits != "00000001") begin n_bad++; $display("FAIL empty_bits: got %s expected 00000001", got_bits); end
    n_cmp++; if (n_xfer !== 0 || n_ready !== 1) begin n_bad++; $display("FAIL empty_handshake: got xfer %0d ready %0d expected 0 1", n_xfer, n_ready); end
    n_cmp++; if (n_eop !== 1) begin n_bad++; $display("FAIL empty_eop: got %0d expected 1", n_eop); end
    @(negedge gclk);
  endtask

  task automatic test_reset_mid_packet();
    bit stray = 1'b0;
    tx_valid = 1'b1; tx_data = 8'hFF;
    repeat (12) @(negedge gclk);
    #2 reset_l = 1'b0;
    #1;
    n_cmp++; if (start_txd !== 1'b0 || tx_data_in !== 1'b1 || tx_eop !== 1'b0 || tx_ready !== 1'b0) begin
      n_bad++; $display("FAIL midrst_outputs: got start %b data %b eop %b ready %b expected 0 1 0 0", start_txd, tx_data_in, tx_eop, tx_ready);
    end
    tx_valid = 1'b0;
    @(negedge gclk); reset_l = 1'b1;
    repeat (3) begin
      @(negedge gclk);
      if (tx_eop !== 1'b0 || start_txd !== 1'b0) stray = 1'b1;
    end
    n_cmp++; if (stray !== 1'b0) begin n_bad++; $display("FAIL midrst_quiet: got activity %b expected 0", stray); end
    pkt[0] = 8'hFF;
    run_packet(1);
    n_cmp++; if (got_bits != "00000001111110111") begin n_bad++; $display("FAIL midrst_restart_bits: got %s expected 00000001111110111", got_bits); end
    n_cmp++; if (n_eop !== 1) begin n_bad++; $display("FAIL midrst_restart_eop: got %0d expected 1", n_eop); end
    @(negedge gclk);
  endtask

  task automatic test_restart_after_eop();
    pkt[0] = 8'hFF;
    run_packet(1);
    n_cmp++; if (ones_eop !== 3) begin n_bad++; $display("FAIL reeop_first_ones: got %0d expected 3", ones_eop); end
    pkt[0] = 8'h3F;
    run_packet(1);
    n_cmp++; if (lead_idle !== 1) begin n_bad++; $display("FAIL reeop_gap: got %0d expected 1", lead_idle); end
    n_cmp++; if (ones_first !== 0) begin n_bad++; $display("FAIL reeop_ones_cleared: got %0d expected 0", ones_first); end
    n_cmp++; if (got_bits != "00000001111110100") begin n_bad++; $display("FAIL reeop_bits: got %s expected 00000001111110100", got_bits); end
    n_cmp++; if (n_eop !== 1) begin n_bad++; $display("FAIL reeop_eop: got %0d expected 1", n_eop); end
    @(negedge gclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_byte_00();
    test_stuff_ff();
    test_stuff_boundary();
    test_back_to_back();
    test_empty_packet();
    test_reset_mid_packet();
    test_restart_after_eop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
